// File: rtl/qcl_piso_shift_ctrl.sv
// qcl_piso_shift_ctrl
//   Sequencer for an els_p-element parallel-in/serial-out shift register.
//   It accepts one parallel word per v_i/ready_o handshake and pulses load_o
//   to the datapath. It presents each serial element with v_o, and the
//   consumer takes the element with yumi_i. shift_o pulses to advance the
//   datapath. last_o marks the final element of a word.
//
// Ports
//   clk_i    : clock
//   reset_i  : asynchronous active-high reset; every output is 0 while asserted
//   v_i      : producer has a word on the datapath input
//   ready_o  : controller accepts a word this cycle (depends on yumi_i)
//   len_i    : elements to emit minus 1 (only with QCL_PISO_SHIFT_CTRL_LEN_EN)
//   load_o   : datapath load strobe
//   shift_o  : datapath shift strobe
//   v_o      : datapath serial output holds a valid element
//   yumi_i   : consumer takes the current element
//   last_o   : current element is the last of its word
//
// Build option
//   QCL_PISO_SHIFT_CTRL_LEN_EN : adds len_i for a per-word element count.
//                                Otherwise every word emits els_p elements.

module qcl_piso_shift_ctrl #(
  parameter  int els_p     = 4,
  localparam int lg_els_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 v_i,
  output logic                 ready_o,
`ifdef QCL_PISO_SHIFT_CTRL_LEN_EN
  input  logic [lg_els_lp-1:0] len_i,
`endif
  output logic                 load_o,
  output logic                 shift_o,
  output logic                 v_o,
  input  logic                 yumi_i,
  output logic                 last_o
);

  if (els_p < 2) begin : g_bad_els
    $fatal(1, "qcl_piso_shift_ctrl: els_p must be greater than 1");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [lg_els_lp-1:0] last_max = lg_els_lp'(els_p - 1);

  logic [0:0]           state_r;
  logic [lg_els_lp-1:0] cnt_r;
  logic [lg_els_lp-1:0] last_idx_r;
  logic [lg_els_lp-1:0] last_idx_n;
  logic                 busy;
  logic                 at_last;

  always_comb begin
`ifdef QCL_PISO_SHIFT_CTRL_LEN_EN
    // Out-of-range lengths saturate to a full word.
    last_idx_n = (len_i > last_max) ? last_max : len_i;
`else
    last_idx_n = last_max;
`endif
  end

  assign busy    = (state_r == BUSY);
  assign at_last = (cnt_r == last_idx_r);

  // ready_o looks at yumi_i in the same cycle. The next word can then load
  // while the last element of the current word leaves, with no bubble.
  assign ready_o = ~reset_i & (~busy | (at_last & yumi_i));
  assign load_o  = v_i & ready_o;
  assign v_o     = busy;
  assign last_o  = v_o & at_last;
  assign shift_o = v_o & yumi_i & ~at_last;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      last_idx_r <= last_max;
    end else if (load_o) begin
      state_r    <= BUSY;
      cnt_r      <= '0;
      last_idx_r <= last_idx_n;
    end else if (busy && yumi_i) begin
      if (at_last) begin
        state_r <= IDLE;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + lg_els_lp'(1);
      end
    end
  end

`ifndef SYNTHESIS
  a_yumi_needs_v : assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> v_o)
    else $error("qcl_piso_shift_ctrl: yumi_i while v_o is low");

  a_load_shift_excl : assert property (@(posedge clk_i) disable iff (reset_i)
    !(load_o && shift_o))
    else $error("qcl_piso_shift_ctrl: load_o and shift_o together");

`ifdef QCL_PISO_SHIFT_CTRL_LEN_EN
  a_len_range : assert property (@(posedge clk_i) disable iff (reset_i)
    load_o |-> (len_i <= last_max))
    else $error("qcl_piso_shift_ctrl: len_i exceeds els_p-1");
`endif
`endif

endmodule

// File: tb/tb_qcl_piso_shift_ctrl.sv
module tb_qcl_piso_shift_ctrl;

  localparam int els_p = 4;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        v_i = 1'b0;
  logic        yumi_want = 1'b0;
  logic        yumi_i;
  logic        ready_o, load_o, shift_o, v_o, last_o;
  logic [31:0] data_in = '0;
  logic [31:0] dp_model = '0;
`ifdef QCL_PISO_SHIFT_CTRL_LEN_EN
  logic [1:0]  len_i = 2'd3;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [8:0]  sb_q[$];

  // Well-behaved consumer: only takes an element when one is offered.
  assign yumi_i = yumi_want & v_o;

  always #5 clk = ~clk;

  qcl_piso_shift_ctrl #(.els_p(els_p)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .v_i     (v_i),
    .ready_o (ready_o),
`ifdef QCL_PISO_SHIFT_CTRL_LEN_EN
    .len_i   (len_i),
`endif
    .load_o  (load_o),
    .shift_o (shift_o),
    .v_o     (v_o),
    .yumi_i  (yumi_i),
    .last_o  (last_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and datapath model. Both run mid-cycle, once the inputs and
  // the combinational outputs have settled.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (v_o && yumi_i) begin
        if (sb_q.size() == 0) chk("sb_empty", sb_q.size(), 1);
        else begin
          logic [8:0] e;
          e = sb_q.pop_front();
          chk("sb_data", {24'd0, dp_model[7:0]}, {24'd0, e[7:0]});
          chk("sb_last", {31'd0, last_o}, {31'd0, e[8]});
        end
      end
      if (v_i && ready_o) begin
        int unsigned n;
`ifdef QCL_PISO_SHIFT_CTRL_LEN_EN
        n = int'(len_i) + 1;
`else
        n = els_p;
`endif
        for (int unsigned k = 0; k < n; k++)
          sb_q.push_back({k == n - 1, data_in[k*8 +: 8]});
      end
      if (load_o) dp_model = data_in;
      else if (shift_o) dp_model = dp_model >> 8;
    end
  end

  // Drive one cycle of inputs after the edge, and return before the next edge
  // so that the caller can sample the outputs.
  task automatic step(input logic vi, input logic yw);
    @(posedge clk);
    #1;
    v_i       = vi;
    yumi_want = yw;
    data_in   = $urandom;
    #3;
  endtask

  function automatic logic [4:0] outs();
    return {ready_o, load_o, shift_o, v_o, last_o};
  endfunction

  initial begin
    int unsigned vo_cnt, ll_cnt, sh_cnt, la_cnt, yc;
    logic [6:0] pat;

    // Reset: every output is low even with v_i high.
    v_i = 1'b1;
    yumi_want = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outs", {27'd0, outs()}, 32'd0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    v_i = 1'b0;
    #3;
    chk("post_reset", {27'd0, outs()}, {27'd0, 5'b10000});

    // Test 1: a single word with yumi_i held high.
    step(1, 1); chk("t1_T0", {27'd0, outs()}, {27'd0, 5'b11000});
    step(0, 1); chk("t1_T1", {27'd0, outs()}, {27'd0, 5'b00110});
    step(0, 1); chk("t1_T2", {27'd0, outs()}, {27'd0, 5'b00110});
    step(0, 1); chk("t1_T3", {27'd0, outs()}, {27'd0, 5'b00110});
    step(0, 1); chk("t1_T4", {27'd0, outs()}, {27'd0, 5'b10011});
    step(0, 1); chk("t1_T5", {27'd0, outs()}, {27'd0, 5'b10000});

    // Test 2: three back-to-back words.
    vo_cnt = 0; ll_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(i <= 8, 1);
      if (v_o) vo_cnt++;
      if (load_o && last_o) ll_cnt++;
      if (i == 1 || i == 12) chk("t2_vo_edge", {31'd0, v_o}, 32'd1);
      if (i == 13) chk("t2_vo_end", {31'd0, v_o}, 32'd0);
    end
    chk("t2_vo_beats", vo_cnt, 12);
    chk("t2_load_at_last", ll_cnt, 2);

    // Test 3: consumer stalls, with yumi_i pattern 1,0,0,1,0,1,1.
    pat = 7'b1101001;  // bit k is the cycle-k yumi
    step(1, 0);
    yc = 0;
    for (int k = 0; k < 7; k++) begin
      step(0, pat[k]);
      chk("t3_shift", {31'd0, shift_o}, {31'd0, pat[k] && yc < 3});
      chk("t3_last", {31'd0, last_o}, {31'd0, yc == 3});
      if (pat[k]) yc++;
    end
    step(0, 0); chk("t3_idle", {31'd0, v_o}, 32'd0);

    // Test 4: asynchronous reset in mid-word (cnt_r=2).
    step(1, 1);
    step(0, 1);
    step(0, 1);
    @(posedge clk);
    #1;
    v_i = 1'b0;
    yumi_want = 1'b1;
    #2;
    reset_i = 1'b1;
    #1;
    chk("t4_rst_outs", {27'd0, outs()}, 32'd0);
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    sb_q.delete();
    #3;
    chk("t4_post", {30'd0, ready_o, v_o}, {30'd0, 2'b10});
    step(1, 1);
    vo_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1);
      if (v_o) vo_cnt++;
    end
    chk("t4_beats", vo_cnt, 4);

    // Test 5: producer waits while a word is in flight.
    step(1, 1);
    step(0, 1);
    step(1, 1); chk("t5_cnt1", {30'd0, ready_o, load_o}, 32'd0);
    step(1, 1); chk("t5_cnt2", {30'd0, ready_o, load_o}, 32'd0);
    step(1, 1); chk("t5_last", {29'd0, ready_o, load_o, last_o}, {29'd0, 3'b111});
    for (int i = 0; i < 6; i++) step(0, 1);
    chk("t5_idle", {31'd0, v_o}, 32'd0);

`ifdef QCL_PISO_SHIFT_CTRL_LEN_EN
    // Test 6: per-word element count.
    for (int j = 0; j < 3; j++) begin
      logic [1:0] l;
      l = (j == 0) ? 2'd1 : (j == 1) ? 2'd3 : 2'd0;
      len_i = l;
      step(1, 1);
      vo_cnt = 0; sh_cnt = 0; la_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        step(0, 1);
        if (v_o) vo_cnt++;
        if (shift_o) sh_cnt++;
        if (last_o) la_cnt++;
      end
      chk("t6_beats", vo_cnt, int'(l) + 1);
      chk("t6_shifts", sh_cnt, int'(l));
      chk("t6_lasts", la_cnt, 1);
    end
`endif

    step(0, 0);
    chk("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
